mcu_el2_lsu_clkgate_ctrl: RTL and testbench
===========================================

Name: mcu_el2_lsu_clkgate_ctrl

Overview:
- Parametrised N-channel clock-gate controller for the LSU and neighbouring pipe/buffer domains.
- Each channel turns a raw activity request into a clock enable plus a gated l1clk. Over a fixed one-shot enable it adds:
  - a runtime-programmable hold-off (hysteresis) counter;
  - optional stage-to-stage chaining (request in stage i wakes stage i+1 one cycle later);
  - optional bus-clock-enable qualification.
- Sits between LSU/DMA request sources and the clock headers; replaces hand-written per-domain enable equations.

Parameters:
- NUM_CH, 8, number of gated clock channels (1..32).
- HOLD_W, 4, width of the hold-off counter and of cfg_hold.
- CHAIN_MASK, {NUM_CH{1'b0}}, bit i=1: channel i's registered request also enables channel i+1 (bit NUM_CH-1 ignored).
- QUAL_MASK, {NUM_CH{1'b0}}, bit i=1: channel i enable is ANDed with bus_clk_en.

Ports:
- clk  in  1  free-running active clock.
- rst_l  in  1  asynchronous active-low reset.
- scan_mode  in  1  scan mode, passed to clock headers.
- clk_override  in  1  forces every enable high.
- dec_tlu_force_halt  in  1  forces every enable high while asserted.
- bus_clk_en  in  1  bus clock enable for qualified channels.
- ch_req  in  NUM_CH  raw per-channel activity request.
- cfg_hold  in  HOLD_W  hold-off cycles after a request drops (shared by all channels).
- ch_clken  out  NUM_CH  per-channel clock enable.
- ch_l1clk  out  NUM_CH  per-channel gated clock (mcu_rvoclkhdr per channel).
- ch_busy  out  NUM_CH  registered: channel counter nonzero.
- stat_sel  in  $clog2(NUM_CH) (min 1)  statistics channel select.
- stat_clr  in  1  clear all statistics counters.
- stat_cnt  out  32  selected channel's enabled-cycle count.

Behaviour:
- Per-channel registers: req_q[i] (registered ch_req[i]) and cnt[i] (HOLD_W bits). All reset to 0 asynchronously.
- Effective request: req_eff[i] = ch_req[i] | (i>0 & CHAIN_MASK[i-1] & req_q[i-1]).
- Counter update per cycle:
  - req_eff[i]=1 → cnt[i] <= cfg_hold;
  - else if cnt[i]!=0 → cnt[i] <= cnt[i]-1;
  - else hold at 0.
- Channel states, derived from registers:
  - ACTIVE (req_eff=1);
  - HOLD (req_eff=0, cnt!=0);
  - IDLE (req_eff=0, cnt==0).
- Raw enable: en_raw[i] = req_eff[i] | (cnt[i]!=0) | clk_override | dec_tlu_force_halt. Combinational, zero latency from ch_req.
- Output enable: ch_clken[i] = QUAL_MASK[i] ? en_raw[i] & bus_clk_en : en_raw[i].
- Hold-off rule: after the last request cycle, the enable stays high for exactly cfg_hold further cycles. cfg_hold=0 → ch_clken follows req_eff exactly.
- A new request during HOLD reloads the counter to cfg_hold; no saturation or wrap is possible.
- A cfg_hold change takes effect at the next reload only; an in-flight countdown is unaffected.
- clk_override and force_halt do not modify cnt or req_q, so state tracking stays correct when they deassert.
- Reset values: ch_busy=0, stat counters=0. With inputs low, ch_clken=0 and ch_l1clk is held low.
- Reset mid-HOLD: counter clears immediately; the enable drops asynchronously unless the request or an override is present.
- ch_busy[i] = registered (cnt[i]!=0), one cycle late relative to cnt.

Optional Feature:
- Macro: MCU_LSU_CLKGATE_STATS_EN.
- Defined:
  - each channel has a 32-bit counter that increments on every cycle ch_clken[i]=1;
  - the counter saturates at 0xFFFF_FFFF;
  - stat_clr zeroes all counters next cycle and has priority over increment;
  - stat_cnt = counter[stat_sel], combinational;
  - stat_sel >= NUM_CH returns 0.
- Undefined: no counters; stat_cnt tied to 0; stat_sel and stat_clr unused.

Decomposition:
- mcu_el2_pkg additions:
  - localparam MCU_CLKGATE_STAT_W=32;
  - typedef enum {CG_IDLE, CG_ACTIVE, CG_HOLD} mcu_el2_cg_state_t, for debug/assertions.
- Sub-module mcu_el2_clkgate_ch: one channel's req_q, counter, enable logic, optional stat counter and mcu_rvoclkhdr. The top is a generate loop plus chain wiring and the stat mux.

Test Plan:
- Hold-off: cfg_hold=3, ch_req[0] single-cycle pulse at t → ch_clken[0]=1 at t..t+3, 0 at t+4; ch_busy[0]=1 at t+2..t+4.
- Zero hold: cfg_hold=0, ch_req[2] high t..t+4 → ch_clken[2] high exactly t..t+4.
- Chaining: CHAIN_MASK[0]=1, cfg_hold=0, ch_req[0] pulse at t → ch_clken[1]=1 at t+1 only.
- Reload and qualification:
  - QUAL_MASK[3]=1, bus_clk_en toggling, ch_req[3]=1 → ch_clken[3] equals bus_clk_en.
  - ch_req[3] re-pulsed during HOLD → counter reloads; enable extends cfg_hold cycles past the new pulse.
- Overrides and reset:
  - clk_override=1, all requests 0 → all ch_clken=1 and cnt stays 0;
  - rst_l asserted mid-HOLD (cnt=2) → ch_clken=0 immediately.
- Stats (MCU_LSU_CLKGATE_STATS_EN):
  - ch_req[1] high 10 cycles, cfg_hold=2, stat_sel=1 → stat_cnt=12;
  - stat_clr → 0 next cycle.

Source files
------------

// File: rtl/mcu_el2_pkg.sv
// Shared types for the LSU clock-gate controller: channel state encoding and stat width.
package mcu_el2_pkg;

  localparam int MCU_CLKGATE_STAT_W = 32;

  typedef enum logic [1:0] {CG_IDLE, CG_ACTIVE, CG_HOLD} mcu_el2_cg_state_t;

  // A live request always wins over a draining hold-off counter.
  function automatic mcu_el2_cg_state_t cg_state(input logic req_eff, input logic cnt_nz);
    if (req_eff)     return CG_ACTIVE;
    else if (cnt_nz) return CG_HOLD;
    else             return CG_IDLE;
  endfunction

endpackage

// File: rtl/mcu_el2_clkgate_ch.sv
// One gated-clock channel: request register, hold-off counter, enable, header.
// Per-channel enabled-cycle counter exists only with MCU_LSU_CLKGATE_STATS_EN.
module mcu_el2_clkgate_ch
  import mcu_el2_pkg::*;
#(
  parameter int HOLD_W = 4,
  parameter bit QUAL   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          scan_mode,
  input  logic                          force_en,
  input  logic                          bus_clk_en,
  input  logic                          req,
  input  logic                          chain_req,
  input  logic [HOLD_W-1:0]             cfg_hold,
  input  logic                          stat_clr,
  output logic                          req_q,
  output logic                          clken,
  output logic                          l1clk,
  output logic                          busy,
  output logic [MCU_CLKGATE_STAT_W-1:0] stat_cnt
);

  logic              req_eff;
  logic              cnt_nz;
  logic              en_raw;
  logic [HOLD_W-1:0] cnt;
  mcu_el2_cg_state_t state;

  assign req_eff = req | chain_req;
  assign cnt_nz  = |cnt;
  assign state   = cg_state(req_eff, cnt_nz);

  // Overrides only touch the enable, never cnt/req_q, so tracking resumes cleanly.
  assign en_raw = (state != CG_IDLE) | force_en;
  assign clken  = QUAL ? (en_raw & bus_clk_en) : en_raw;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      req_q <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      req_q <= req;
      busy  <= cnt_nz;
      case (state)
        CG_ACTIVE: cnt <= cfg_hold;
        CG_HOLD:   cnt <= cnt - 1'b1;
        default:   cnt <= cnt;
      endcase
    end
  end

  mcu_rvoclkhdr u_clkhdr (
    .clk       (clk),
    .en        (clken),
    .scan_mode (scan_mode),
    .l1clk     (l1clk)
  );

`ifdef MCU_LSU_CLKGATE_STATS_EN
  logic [MCU_CLKGATE_STAT_W-1:0] stat_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                    stat_q <= '0;
    else if (stat_clr)             stat_q <= '0;
    else if (clken && stat_q != '1) stat_q <= stat_q + 1'b1;
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: rtl/mcu_rvoclkhdr.sv
// Glitch-free clock header: enable latched while clk is low, then ANDed with clk.
module mcu_rvoclkhdr (
  input  logic clk,
  input  logic en,
  input  logic scan_mode,
  output logic l1clk
);

  logic en_lat;

  always_latch begin
    if (!clk) en_lat = en | scan_mode;
  end

  assign l1clk = clk & en_lat;

endmodule

// File: rtl/mcu_el2_lsu_clkgate_ctrl.sv
// N-channel LSU clock-gate controller: per-channel hold-off, optional chaining and
// bus qualification. Enabled-cycle statistics under MCU_LSU_CLKGATE_STATS_EN.
module mcu_el2_lsu_clkgate_ctrl
  import mcu_el2_pkg::*;
#(
  parameter int                NUM_CH     = 8,
  parameter int                HOLD_W     = 4,
  parameter logic [NUM_CH-1:0] CHAIN_MASK = '0,
  parameter logic [NUM_CH-1:0] QUAL_MASK  = '0
) (
  input  logic                                             clk,
  input  logic                                             rst_l,
  input  logic                                             scan_mode,
  input  logic                                             clk_override,
  input  logic                                             dec_tlu_force_halt,
  input  logic                                             bus_clk_en,
  input  logic [NUM_CH-1:0]                                ch_req,
  input  logic [HOLD_W-1:0]                                cfg_hold,
  output logic [NUM_CH-1:0]                                ch_clken,
  output logic [NUM_CH-1:0]                                ch_l1clk,
  output logic [NUM_CH-1:0]                                ch_busy,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   stat_sel,
  input  logic                                             stat_clr,
  output logic [MCU_CLKGATE_STAT_W-1:0]                    stat_cnt
);

  logic                                          force_en;
  logic [NUM_CH-1:0]                             req_q;
  logic [NUM_CH-1:0]                             chain_req;
  logic [NUM_CH-1:0][MCU_CLKGATE_STAT_W-1:0]     stat_vec;
  logic                                          unused_last_req_q;

  assign force_en          = clk_override | dec_tlu_force_halt;
  assign unused_last_req_q = req_q[NUM_CH-1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Chaining uses the raw registered request, so a wake never ripples past one stage.
    if (i == 0) begin : g_head
      assign chain_req[i] = 1'b0;
    end else begin : g_link
      assign chain_req[i] = CHAIN_MASK[i-1] & req_q[i-1];
    end

    mcu_el2_clkgate_ch #(
      .HOLD_W (HOLD_W),
      .QUAL   (QUAL_MASK[i])
    ) u_ch (
      .clk        (clk),
      .rst_l      (rst_l),
      .scan_mode  (scan_mode),
      .force_en   (force_en),
      .bus_clk_en (bus_clk_en),
      .req        (ch_req[i]),
      .chain_req  (chain_req[i]),
      .cfg_hold   (cfg_hold),
      .stat_clr   (stat_clr),
      .req_q      (req_q[i]),
      .clken      (ch_clken[i]),
      .l1clk      (ch_l1clk[i]),
      .busy       (ch_busy[i]),
      .stat_cnt   (stat_vec[i])
    );
  end

  always_comb begin
    stat_cnt = '0;
    if (32'(stat_sel) < NUM_CH) stat_cnt = stat_vec[stat_sel];
  end

endmodule

// File: tb/tb_mcu_el2_lsu_clkgate_ctrl.sv
// Bench for mcu_el2_lsu_clkgate_ctrl: directed vector table, corner sequences, random vs model.
module tb_mcu_el2_lsu_clkgate_ctrl;

  localparam int         N  = 8;
  localparam int         HW = 4;
  localparam logic [7:0] CM = 8'h11;
  localparam logic [7:0] QM = 8'h08;
  localparam int         IDLE_AGE = 1000;

  logic          clk = 1'b0;
  logic          rst_l, scan_mode, clk_override, dec_tlu_force_halt, bus_clk_en, stat_clr;
  logic [N-1:0]  ch_req, ch_clken, ch_l1clk, ch_busy;
  logic [HW-1:0] cfg_hold;
  logic [2:0]    stat_sel;
  logic [31:0]   stat_cnt;

  int n_chk = 0;
  int n_fail = 0;

  mcu_el2_lsu_clkgate_ctrl #(
    .NUM_CH(N), .HOLD_W(HW), .CHAIN_MASK(CM), .QUAL_MASK(QM)
  ) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .clk_override(clk_override),
    .dec_tlu_force_halt(dec_tlu_force_halt), .bus_clk_en(bus_clk_en), .ch_req(ch_req),
    .cfg_hold(cfg_hold), .ch_clken(ch_clken), .ch_l1clk(ch_l1clk), .ch_busy(ch_busy),
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [3:0] hold;
    logic       ovr;
    logic       halt;
    logic       bus;
    logic [7:0] exp_en;
    logic [7:0] exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic [3:0] h, input logic o, input logic hl,
                     input logic b, input logic [7:0] en, input logic [7:0] bz);
    vec_t v;
    v.req = r; v.hold = h; v.ovr = o; v.halt = hl; v.bus = b; v.exp_en = en; v.exp_busy = bz;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic [3:0] h, input logic o, input logic hl,
                       input logic b);
    ch_req = r; cfg_hold = h; clk_override = o; dec_tlu_force_halt = hl; bus_clk_en = b;
  endtask

  // Reference model: age = cycles since the channel's last effective request.
  int          age[N];
  int          holdl[N];
  logic [7:0]  prevreq, busy_m;
  longint      stat_m[N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      age[i] = IDLE_AGE; holdl[i] = 0; stat_m[i] = 0;
    end
    prevreq = '0; busy_m = '0;
  endfunction

  function automatic logic [7:0] eff_req();
    logic [7:0] e;
    for (int i = 0; i < N; i++)
      e[i] = ch_req[i] | (i > 0 && CM[i-1] && prevreq[i-1]);
    return e;
  endfunction

  function automatic logic in_hold(int i);
    return age[i] >= 1 && age[i] <= holdl[i];
  endfunction

  function automatic logic [7:0] exp_clken();
    logic [7:0] e, en;
    e = eff_req();
    for (int i = 0; i < N; i++) begin
      en[i] = e[i] | in_hold(i) | clk_override | dec_tlu_force_halt;
      if (QM[i]) en[i] = en[i] & bus_clk_en;
    end
    return en;
  endfunction

  function automatic void model_tick();
    logic [7:0] e, en;
    e  = eff_req();
    en = exp_clken();
    for (int i = 0; i < N; i++) begin
      busy_m[i] = in_hold(i);
      if (e[i]) begin
        age[i] = 1; holdl[i] = int'(cfg_hold);
      end else if (age[i] < IDLE_AGE) age[i]++;
      if (stat_clr) stat_m[i] = 0;
      else if (en[i] && stat_m[i] < 64'hFFFF_FFFF) stat_m[i]++;
    end
    prevreq = ch_req;
  endfunction

  function automatic logic [31:0] exp_stat();
`ifdef MCU_LSU_CLKGATE_STATS_EN
    return 32'(stat_m[stat_sel]);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    rst_l = 1'b0; scan_mode = 1'b0; stat_clr = 1'b0; stat_sel = '0;
    drive(8'h00, 4'd0, 1'b0, 1'b0, 1'b1);

    // hold-off + chain 0->1, zero hold, chain with zero hold, qualification, reload, overrides
    add(8'h01,3,0,0,1, 8'h01,8'h00); add(8'h00,3,0,0,1, 8'h03,8'h00);
    add(8'h00,3,0,0,1, 8'h03,8'h01); add(8'h00,3,0,0,1, 8'h03,8'h03);
    add(8'h00,3,0,0,1, 8'h02,8'h03); add(8'h00,3,0,0,1, 8'h00,8'h02);
    add(8'h00,3,0,0,1, 8'h00,8'h00);
    for (int k = 0; k < 5; k++) add(8'h04,0,0,0,1, 8'h04,8'h00);
    add(8'h00,0,0,0,1, 8'h00,8'h00);
    add(8'h01,0,0,0,1, 8'h01,8'h00); add(8'h00,0,0,0,1, 8'h02,8'h00);
    add(8'h00,0,0,0,1, 8'h00,8'h00);
    add(8'h08,2,0,0,1, 8'h08,8'h00); add(8'h08,2,0,0,0, 8'h00,8'h00);
    add(8'h08,2,0,0,1, 8'h08,8'h08); add(8'h00,2,0,0,1, 8'h08,8'h08);
    add(8'h08,2,0,0,1, 8'h08,8'h08); add(8'h00,2,0,0,1, 8'h08,8'h08);
    add(8'h00,2,0,0,1, 8'h08,8'h08); add(8'h00,2,0,0,1, 8'h00,8'h08);
    add(8'h00,2,0,0,1, 8'h00,8'h00);
    add(8'h00,2,1,0,1, 8'hFF,8'h00); add(8'h00,2,1,0,1, 8'hFF,8'h00);
    add(8'h00,2,0,0,1, 8'h00,8'h00); add(8'h00,2,0,1,0, 8'hF7,8'h00);
    add(8'h00,2,0,0,1, 8'h00,8'h00);

    #12;
    chk("reset_clken", 32'(ch_clken), 32'h0);
    chk("reset_busy",  32'(ch_busy),  32'h0);
    chk("reset_stat",  stat_cnt,      32'h0);
    @(negedge clk); rst_l = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[k]) begin
      if (k > 0) @(negedge clk);
      drive(tbl[k].req, tbl[k].hold, tbl[k].ovr, tbl[k].halt, tbl[k].bus);
      #1;
      chk($sformatf("tbl%0d_clken", k), 32'(ch_clken), 32'(tbl[k].exp_en));
      chk($sformatf("tbl%0d_busy", k),  32'(ch_busy),  32'(tbl[k].exp_busy));
    end

    // reset in the middle of a hold-off countdown (ch0 cnt=2, ch1 cnt=3)
    @(negedge clk); drive(8'h01, 4'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(8'h00, 4'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("pre_rst_clken", 32'(ch_clken), 32'h03);
    #1 rst_l = 1'b0; #1;
    chk("mid_hold_rst_clken", 32'(ch_clken), 32'h00);
    chk("mid_hold_rst_busy",  32'(ch_busy),  32'h00);
    @(negedge clk); @(negedge clk); rst_l = 1'b1;

    // enabled-cycle statistics: 10 request cycles + 2 hold cycles
    stat_sel = 3'd1;
    for (int k = 0; k < 10; k++) begin
      drive(8'h02, 4'd2, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(8'h00, 4'd2, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
`ifdef MCU_LSU_CLKGATE_STATS_EN
    chk("stat_12", stat_cnt, 32'd12);
`else
    chk("stat_tied0", stat_cnt, 32'd0);
`endif
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0; #1;
    chk("stat_clr", stat_cnt, 32'd0);

    // randomized run against the model
    @(negedge clk); rst_l = 1'b0;
    @(negedge clk); rst_l = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ch_req = 8'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) cfg_hold = 4'($urandom_range(0, 15));
      clk_override       = ($urandom_range(0, 31) == 0);
      dec_tlu_force_halt = ($urandom_range(0, 31) == 0);
      bus_clk_en         = 1'($urandom);
      stat_clr           = ($urandom_range(0, 63) == 0);
      stat_sel           = 3'($urandom_range(0, 7));
      #1;
      chk($sformatf("rnd%0d_clken", c), 32'(ch_clken), 32'(exp_clken()));
      chk($sformatf("rnd%0d_busy", c),  32'(ch_busy),  32'(busy_m));
      chk($sformatf("rnd%0d_stat", c),  stat_cnt,      exp_stat());
      @(posedge clk);
      model_tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
